packetmem_nbuf: RTL and testbench
=================================

# packetmem_nbuf

Parametrised successor to the three-buffer packet memory. It holds NUM_BUFS packet buffers and circulates them among three agents: snooper (writer), CPU (filter, reader) and forwarder (reader). Buffers are held in a free pool, a CPU queue and a forwarder queue, so several filtered packets can wait for the forwarder while the snooper keeps capturing. It sits between the snooper, the BPF CPU and the forwarder, in place of the fixed ping/pang/pung arrangement.

## Interface
- NUM_BUFS, 4, buffer count; legal range 2–16.
- ADDR_WIDTH, 9, word address width per buffer; each buffer is 2^ADDR_WIDTH words.
- DATA_WIDTH, 64, word width shared by the snooper, CPU and forwarder ports.
- clk  in  1  Sole clock.
- rst_n  in  1  Asynchronous, active-low reset.
- snooper_wr_addr  in  ADDR_WIDTH  Write word address.
- snooper_wr_data  in  DATA_WIDTH  Write data.
- snooper_wr_en  in  1  Write strobe.
- snooper_done  in  1  1-cycle pulse marking end of packet.
- ready_for_snooper  out  1  The snooper owns a buffer.
- cpu_rd_addr  in  ADDR_WIDTH  CPU read word address.
- cpu_rd_en  in  1  CPU read strobe.
- cpu_rd_data  out  DATA_WIDTH  Registered CPU read data.
- cpu_acc  in  1  1-cycle pulse: pass the packet to the forwarder.
- cpu_rej  in  1  1-cycle pulse: drop the packet.
- ready_for_cpu  out  1  The CPU queue is non-empty.
- len_to_cpu  out  ADDR_WIDTH+1  Length in words of the CPU head buffer.
- forwarder_rd_addr  in  ADDR_WIDTH  Forwarder read word address.
- forwarder_rd_en  in  1  Forwarder read strobe.
- forwarder_rd_data  out  DATA_WIDTH  Registered forwarder read data.
- forwarder_done  in  1  1-cycle pulse: release the forwarder head buffer.
- ready_for_forwarder  out  1  The forwarder queue is non-empty.
- len_to_forwarder  out  ADDR_WIDTH+1  Length in words of the forwarder head buffer.

## Operation
**Buffer pools**
- The free pool is a NUM_BUFS-bit bitmap. Allocation takes the lowest set index.
- The CPU queue and forwarder queue are first-word-fall-through (FWFT) index FIFOs, each NUM_BUFS deep. They cannot overflow.

**Snooper**
- The snooper holds a current-buffer register plus a valid bit.
- Writes when the valid bit is 0 are ignored.
- On snooper_done with valid set: push the current index to the CPU queue. At the same edge, allocate the lowest free index, or clear valid if the pool is empty.
- With valid clear and the pool non-empty: allocate at the next edge.

**Length tracking**
- Each buffer has a length register. On every accepted write, len = max(len, wr_addr+1).
- Length is cleared when the buffer returns to the free pool.

**CPU**
- On cpu_acc: pop the CPU head and push it to the forwarder queue.
- On cpu_rej: pop the CPU head and return it to the free pool.
- If cpu_acc and cpu_rej arrive together, cpu_acc wins.
- Both pulses are ignored while ready_for_cpu=0.

**Forwarder**
- On forwarder_done: pop the forwarder head and return it to the free pool. Ignored while ready_for_forwarder=0.
- Simultaneous releases from cpu_rej and forwarder_done both set their bitmap bits at the same edge.

**Reads**
- The CPU reads from its head buffer and the forwarder from its head buffer.
- When rd_en=0, rd_data holds its previous value.

**Ownership**
- Invariant: every index is in exactly one of the free pool, the snooper register, the CPU queue or the forwarder queue.

## Timing
**Reset values**
- ready_for_snooper=1 (buffer 0 preallocated), with free bitmap = all ones except bit 0.
- ready_for_cpu=0, ready_for_forwarder=0.
- Both len outputs = 0 and both rd_data outputs = 0.
- Queues empty and all length registers 0.
- An asserted reset mid-packet discards all buffer contents' ownership and returns to this state.

**Latency**
- Read latency is 1 cycle: data is valid the edge after rd_en.
- Write to memory takes 1 edge.
- A buffer pushed on snooper_done sets ready_for_cpu the next cycle. len_to_cpu is valid at the same time.
- cpu_acc makes the buffer visible to the forwarder the next cycle.
- A buffer released while the snooper is idle sets ready_for_snooper 2 cycles after the release pulse: bitmap update, then allocation.

**Boundary conditions**
- A write and snooper_done in the same cycle: the write lands and counts toward the length.
- Length saturates at 2^ADDR_WIDTH.

## Configuration
- PACKETMEM_NBUF_DROP_CNT_EN: when defined, add output drop_cnt (32 bits, reset 0, saturating). It increments on each snooper_done that arrives with ready_for_snooper=0, and on each cpu_rej.
- Without the macro the port and counter are absent; behaviour is otherwise identical.

## Structure
- Shared package pnmem_pkg holds:
  - the maximum buffer count constant 16;
  - the idx_t width function $clog2(NUM_BUFS);
  - the length width rule ADDR_WIDTH+1.
- Sub-module buf_index_fifo: FWFT FIFO of buffer indices, parametrised by depth and width. It has push, pop, head, empty and count, with a synchronous push/pop and asynchronous active-low reset. It is instantiated twice.
- Buffer RAMs are generated per index, each with one write port and one registered read port. Read data is muxed by queue head.

## Test plan
- Reset, then write addrs 0..9, then snooper_done → ready_for_cpu=1 next cycle, len_to_cpu=10, ready_for_snooper stays 1 (buffer 1).
- CPU reads addr 3 → cpu_rd_data equals the written word 1 cycle later. Then cpu_acc → ready_for_forwarder=1, len_to_forwarder=10, forwarder reads match. Then forwarder_done → that buffer is freed with length 0.
- NUM_BUFS=4: four packets completed with no CPU action → ready_for_snooper=0 after the 4th done; writes are ignored. A 5th snooper_done increments drop_cnt to 1 (macro defined).
- cpu_acc and cpu_rej in the same cycle → the buffer goes to the forwarder queue; free pool unchanged.
- cpu_rej and forwarder_done in the same cycle with an idle snooper → both bitmap bits set, the lowest index is allocated, ready_for_snooper=1 two cycles after the pulses.
- rst_n asserted mid-packet → all outputs return to reset values asynchronously. After release, buffer 0 is reallocated and the length is 0.

Source files
------------

// File: rtl/pnmem_pkg.sv
// Shared constants and width rules for the N-buffer packet memory.
// Used by packetmem_nbuf and buf_index_fifo.
package pnmem_pkg;

  localparam int MAX_BUFS = 16;

  function automatic int idx_w(input int nbufs);
    return (nbufs > 1) ? $clog2(nbufs) : 1;
  endfunction

  function automatic int len_w(input int aw);
    return aw + 1;
  endfunction

endpackage

// File: rtl/buf_index_fifo.sv
// First-word-fall-through FIFO of buffer indices.
// Depth need not be a power of two; pointers wrap explicitly.
module buf_index_fifo
  import pnmem_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_q;
  logic [PW-1:0]    wr_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i &&
                   ((cnt_q != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= nxt(wr_q);
      end
      if (do_pop) rd_q <= nxt(rd_q);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/packetmem_nbuf.sv
// NUM_BUFS packet buffers circulated snooper -> CPU queue -> forwarder queue.
// Optional drop counter: define PACKETMEM_NBUF_DROP_CNT_EN.
module packetmem_nbuf
  import pnmem_pkg::*;
#(
  parameter int NUM_BUFS   = 4,
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] snooper_wr_addr,
  input  logic [DATA_WIDTH-1:0] snooper_wr_data,
  input  logic                  snooper_wr_en,
  input  logic                  snooper_done,
  output logic                  ready_for_snooper,
  input  logic [ADDR_WIDTH-1:0] cpu_rd_addr,
  input  logic                  cpu_rd_en,
  output logic [DATA_WIDTH-1:0] cpu_rd_data,
  input  logic                  cpu_acc,
  input  logic                  cpu_rej,
  output logic                  ready_for_cpu,
  output logic [ADDR_WIDTH:0]   len_to_cpu,
  input  logic [ADDR_WIDTH-1:0] forwarder_rd_addr,
  input  logic                  forwarder_rd_en,
  output logic [DATA_WIDTH-1:0] forwarder_rd_data,
  input  logic                  forwarder_done,
  output logic                  ready_for_forwarder,
  output logic [ADDR_WIDTH:0]   len_to_forwarder
`ifdef PACKETMEM_NBUF_DROP_CNT_EN
  ,
  output logic [31:0]           drop_cnt
`endif
);

  localparam int IW    = idx_w(NUM_BUFS);
  localparam int LW    = len_w(ADDR_WIDTH);
  localparam int CW    = $clog2(NUM_BUFS + 1);
  localparam int WORDS = 1 << ADDR_WIDTH;

  if (NUM_BUFS < 2 || NUM_BUFS > MAX_BUFS) begin : g_bad_cfg
    $error("packetmem_nbuf: NUM_BUFS out of range");
  end

  logic [NUM_BUFS-1:0] free_q, free_d;
  logic [IW-1:0]       snp_idx_q, snp_idx_d;
  logic                snp_vld_q, snp_vld_d;
  logic [LW-1:0]       len_q [NUM_BUFS];
  logic [LW-1:0]       wr_len;

  logic [IW-1:0] cpu_head, fwd_head, low_idx;
  logic          cpu_empty, fwd_empty, low_any;
  logic [CW-1:0] cpu_cnt, fwd_cnt;
  logic          unused_cnt;

  logic wr_ok, snp_push, alloc;
  logic cpu_pop, cpu_fwd, cpu_drop, fwd_pop;
  logic cpu_rd, fwd_rd;

  assign ready_for_snooper   = snp_vld_q;
  assign ready_for_cpu       = !cpu_empty;
  assign ready_for_forwarder = !fwd_empty;

  assign wr_ok    = snooper_wr_en && snp_vld_q;
  assign snp_push = snooper_done && snp_vld_q;
  assign cpu_pop  = ready_for_cpu && (cpu_acc || cpu_rej);
  assign cpu_fwd  = ready_for_cpu && cpu_acc;
  assign cpu_drop = ready_for_cpu && cpu_rej && !cpu_acc;
  assign fwd_pop  = ready_for_forwarder && forwarder_done;
  assign alloc    = (snp_push || !snp_vld_q) && low_any;
  assign cpu_rd   = cpu_rd_en && ready_for_cpu;
  assign fwd_rd   = forwarder_rd_en && ready_for_forwarder;
  assign wr_len   = LW'(snooper_wr_addr) + LW'(1);

  assign unused_cnt = ^{cpu_cnt, fwd_cnt};

  buf_index_fifo #(.DEPTH(NUM_BUFS), .WIDTH(IW)) u_cpu_q (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (snp_push),
    .data_i (snp_idx_q),
    .pop_i  (cpu_pop),
    .head_o (cpu_head),
    .empty_o(cpu_empty),
    .count_o(cpu_cnt)
  );

  buf_index_fifo #(.DEPTH(NUM_BUFS), .WIDTH(IW)) u_fwd_q (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (cpu_fwd),
    .data_i (cpu_head),
    .pop_i  (fwd_pop),
    .head_o (fwd_head),
    .empty_o(fwd_empty),
    .count_o(fwd_cnt)
  );

  always_comb begin
    low_idx = '0;
    low_any = 1'b0;
    for (int i = NUM_BUFS - 1; i >= 0; i--) begin
      if (free_q[i]) begin
        low_idx = IW'(i);
        low_any = 1'b1;
      end
    end
  end

  // Releases only become allocatable from the next edge on.
  always_comb begin
    free_d = free_q;
    if (alloc)    free_d[low_idx]  = 1'b0;
    if (cpu_drop) free_d[cpu_head] = 1'b1;
    if (fwd_pop)  free_d[fwd_head] = 1'b1;
  end

  always_comb begin
    snp_vld_d = snp_vld_q;
    snp_idx_d = snp_idx_q;
    if (alloc) begin
      snp_vld_d = 1'b1;
      snp_idx_d = low_idx;
    end else if (snp_push) begin
      snp_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      free_q    <= {{(NUM_BUFS - 1){1'b1}}, 1'b0};
      snp_idx_q <= '0;
      snp_vld_q <= 1'b1;
    end else begin
      free_q    <= free_d;
      snp_idx_q <= snp_idx_d;
      snp_vld_q <= snp_vld_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_BUFS; i++) len_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_BUFS; i++) begin
        if ((cpu_drop && cpu_head == IW'(i)) ||
            (fwd_pop && fwd_head == IW'(i)))
          len_q[i] <= '0;
        else if (wr_ok && snp_idx_q == IW'(i) &&
                 wr_len > len_q[i])
          len_q[i] <= wr_len;
      end
    end
  end

  assign len_to_cpu       = ready_for_cpu ? len_q[cpu_head] : '0;
  assign len_to_forwarder = ready_for_forwarder ? len_q[fwd_head] : '0;

  logic [DATA_WIDTH-1:0] rd_word [NUM_BUFS];

  // One read port per RAM; the two heads never name the same buffer.
  for (genvar b = 0; b < NUM_BUFS; b++) begin : g_buf
    logic [DATA_WIDTH-1:0] ram [WORDS];
    logic [DATA_WIDTH-1:0] rdat_q;
    logic                  sel_f, sel_c;

    assign sel_f = fwd_rd && fwd_head == IW'(b);
    assign sel_c = cpu_rd && cpu_head == IW'(b);

    always_ff @(posedge clk) begin
      if (wr_ok && snp_idx_q == IW'(b))
        ram[snooper_wr_addr] <= snooper_wr_data;
      if (sel_f)
        rdat_q <= ram[forwarder_rd_addr];
      else if (sel_c)
        rdat_q <= ram[cpu_rd_addr];
    end

    assign rd_word[b] = rdat_q;
  end

  logic                  cpu_pend_q, fwd_pend_q;
  logic [IW-1:0]         cpu_sel_q, fwd_sel_q;
  logic [DATA_WIDTH-1:0] cpu_hold_q, fwd_hold_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_pend_q <= 1'b0;
      fwd_pend_q <= 1'b0;
      cpu_sel_q  <= '0;
      fwd_sel_q  <= '0;
      cpu_hold_q <= '0;
      fwd_hold_q <= '0;
    end else begin
      cpu_pend_q <= cpu_rd;
      fwd_pend_q <= fwd_rd;
      if (cpu_rd)     cpu_sel_q  <= cpu_head;
      if (fwd_rd)     fwd_sel_q  <= fwd_head;
      if (cpu_pend_q) cpu_hold_q <= rd_word[cpu_sel_q];
      if (fwd_pend_q) fwd_hold_q <= rd_word[fwd_sel_q];
    end
  end

  assign cpu_rd_data =
    cpu_pend_q ? rd_word[cpu_sel_q] : cpu_hold_q;
  assign forwarder_rd_data =
    fwd_pend_q ? rd_word[fwd_sel_q] : fwd_hold_q;

`ifdef PACKETMEM_NBUF_DROP_CNT_EN
  logic [31:0] drop_q, drop_d;
  logic [32:0] drop_sum;
  logic [1:0]  drop_inc;

  assign drop_inc = {1'b0, snooper_done && !snp_vld_q} +
                    {1'b0, cpu_drop};
  assign drop_sum = {1'b0, drop_q} + 33'(drop_inc);
  assign drop_d   = drop_sum[32] ? '1 : drop_sum[31:0];
  assign drop_cnt = drop_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_q <= '0;
    else        drop_q <= drop_d;
  end
`endif

endmodule

// File: tb/tb_packetmem_nbuf.sv
// Directed + random check of packetmem_nbuf against a queue-level model.
// drop_cnt is checked when PACKETMEM_NBUF_DROP_CNT_EN is defined.
module tb_packetmem_nbuf;

  localparam int NB    = 4;
  localparam int AW    = 9;
  localparam int DW    = 64;
  localparam int WORDS = 1 << AW;
  localparam logic [DW-1:0] PAT = 64'hA5A5_0000_0000_0000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] wa, cra, fra;
  logic [DW-1:0] wd;
  logic          we, sd, cre, acc, rej, fre, fdone;
  logic          rfs, rfc, rff;
  logic [DW-1:0] crd, frd;
  logic [AW:0]   lc, lf;
`ifdef PACKETMEM_NBUF_DROP_CNT_EN
  logic [31:0]   dcnt;
`endif

  always #5 clk = ~clk;

  packetmem_nbuf #(
    .NUM_BUFS(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .snooper_wr_addr    (wa),
    .snooper_wr_data    (wd),
    .snooper_wr_en      (we),
    .snooper_done       (sd),
    .ready_for_snooper  (rfs),
    .cpu_rd_addr        (cra),
    .cpu_rd_en          (cre),
    .cpu_rd_data        (crd),
    .cpu_acc            (acc),
    .cpu_rej            (rej),
    .ready_for_cpu      (rfc),
    .len_to_cpu         (lc),
    .forwarder_rd_addr  (fra),
    .forwarder_rd_en    (fre),
    .forwarder_rd_data  (frd),
    .forwarder_done     (fdone),
    .ready_for_forwarder(rff),
    .len_to_forwarder   (lf)
`ifdef PACKETMEM_NBUF_DROP_CNT_EN
    , .drop_cnt         (dcnt)
`endif
  );

  // Model: ownership as a bitmap plus two index queues.
  bit            m_free [NB];
  bit            m_vld;
  int            m_idx;
  int            cq[$];
  int            fq[$];
  int            m_len [NB];
  logic [DW-1:0] m_mem [NB][WORDS];
  bit            m_known [NB][WORDS];
  logic [DW-1:0] e_crd, e_frd;
  bit            k_crd, k_frd;
  int            m_drop;

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void m_reset();
    for (int i = 0; i < NB; i++) begin
      m_free[i] = (i != 0);
      m_len[i]  = 0;
    end
    m_vld = 1'b1;
    m_idx = 0;
    cq.delete();
    fq.delete();
    e_crd  = '0;
    e_frd  = '0;
    k_crd  = 1'b1;
    k_frd  = 1'b1;
    m_drop = 0;
  endfunction

  function automatic void m_step();
    bit cpu_rdy, fwd_rdy, need;
    int rel[$];
    cpu_rdy = cq.size() > 0;
    fwd_rdy = fq.size() > 0;
    if (cre) begin
      k_crd = cpu_rdy && m_known[cq[0]][cra];
      if (k_crd) e_crd = m_mem[cq[0]][cra];
    end
    if (fre) begin
      k_frd = fwd_rdy && m_known[fq[0]][fra];
      if (k_frd) e_frd = m_mem[fq[0]][fra];
    end
    if (we && m_vld) begin
      m_mem[m_idx][wa]   = wd;
      m_known[m_idx][wa] = 1'b1;
      if (int'(wa) + 1 > m_len[m_idx]) m_len[m_idx] = int'(wa) + 1;
    end
    if (fwd_rdy && fdone) rel.push_back(fq.pop_front());
    if (cpu_rdy && acc) fq.push_back(cq.pop_front());
    else if (cpu_rdy && rej) begin
      rel.push_back(cq.pop_front());
      m_drop++;
    end
    if (sd && !m_vld) m_drop++;
    need = !m_vld;
    if (sd && m_vld) begin
      cq.push_back(m_idx);
      m_vld = 1'b0;
      need  = 1'b1;
    end
    if (need) begin
      for (int i = 0; i < NB; i++) begin
        if (m_free[i]) begin
          m_idx     = i;
          m_vld     = 1'b1;
          m_free[i] = 1'b0;
          break;
        end
      end
    end
    foreach (rel[j]) begin
      m_free[rel[j]] = 1'b1;
      m_len[rel[j]]  = 0;
    end
  endfunction

  task automatic check_outs();
    chk("rfs", 64'(rfs), 64'(m_vld));
    chk("rfc", 64'(rfc), 64'(cq.size() > 0));
    chk("rff", 64'(rff), 64'(fq.size() > 0));
    chk("len_cpu", 64'(lc),
        (cq.size() > 0) ? 64'(m_len[cq[0]]) : 64'd0);
    chk("len_fwd", 64'(lf),
        (fq.size() > 0) ? 64'(m_len[fq[0]]) : 64'd0);
    if (k_crd) chk("cpu_rd", crd, e_crd);
    if (k_frd) chk("fwd_rd", frd, e_frd);
`ifdef PACKETMEM_NBUF_DROP_CNT_EN
    chk("drop", 64'(dcnt), 64'(m_drop));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) m_step();
    else       m_reset();
    #1;
    check_outs();
  endtask

  task automatic idle();
    we = 0; sd = 0; cre = 0; acc = 0;
    rej = 0; fre = 0; fdone = 0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rfs"}, 64'(rfs), 64'd1);
    chk({tag, "_rfc"}, 64'(rfc), 64'd0);
    chk({tag, "_rff"}, 64'(rff), 64'd0);
    chk({tag, "_lc"},  64'(lc),  64'd0);
    chk({tag, "_lf"},  64'(lf),  64'd0);
    chk({tag, "_crd"}, crd, 64'd0);
    chk({tag, "_frd"}, frd, 64'd0);
  endtask

  initial begin
    idle();
    wa = '0; wd = '0; cra = '0; fra = '0;
    rst_n = 1'b0;
    m_reset();
    repeat (2) tick();
    chk_reset_vals("rst");
    rst_n = 1'b1;

    // First packet: addrs 0..9, done with the last write.
    for (int i = 0; i < 10; i++) begin
      we = 1; wa = AW'(i); wd = PAT | DW'(i); sd = (i == 9);
      tick();
    end
    idle();
    chk("t1_rfc", 64'(rfc), 64'd1);
    chk("t1_len", 64'(lc), 64'd10);
    chk("t1_rfs", 64'(rfs), 64'd1);

    cre = 1; cra = AW'(3); tick(); idle();
    chk("t2_cpu_rd", crd, PAT | 64'd3);
    acc = 1; tick(); idle();
    chk("t2_rff", 64'(rff), 64'd1);
    chk("t2_lenf", 64'(lf), 64'd10);
    fre = 1; fra = AW'(7); tick(); idle();
    chk("t2_fwd_rd", frd, PAT | 64'd7);
    fdone = 1; tick(); idle();
    chk("t2_rff0", 64'(rff), 64'd0);

    // Fill every buffer without CPU action.
    for (int p = 0; p < NB; p++) begin
      we = 1; wa = AW'(p); wd = {$urandom, $urandom}; sd = 1;
      tick();
    end
    idle();
    chk("t4_rfs", 64'(rfs), 64'd0);
    we = 1; wa = AW'(20); wd = '1; tick(); idle();
    sd = 1; tick(); idle();
`ifdef PACKETMEM_NBUF_DROP_CNT_EN
    chk("t4_drop", 64'(dcnt), 64'd1);
`endif

    acc = 1; rej = 1; tick(); idle();
    chk("t5_rff", 64'(rff), 64'd1);
    chk("t5_lenf", 64'(lf), 64'd1);
    chk("t5_rfs", 64'(rfs), 64'd0);

    rej = 1; fdone = 1; tick(); idle();
    chk("t6_rfs_a", 64'(rfs), 64'd0);
    tick();
    chk("t6_rfs_b", 64'(rfs), 64'd1);

    // Reset in the middle of a packet.
    for (int i = 0; i < 5; i++) begin
      we = 1; wa = AW'(i); wd = {$urandom, $urandom}; tick();
    end
    idle();
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("arst");
    m_reset();
    tick();
    rst_n = 1'b1;
    sd = 1; tick(); idle();
    chk("t7_rfc", 64'(rfc), 64'd1);
    chk("t7_len0", 64'(lc), 64'd0);
    rej = 1; tick(); idle();
    we = 1; wa = AW'(WORDS - 1); wd = {$urandom, $urandom};
    tick(); idle();
    sd = 1; tick(); idle();
    chk("t7_sat", 64'(lc), 64'(WORDS));

    for (int c = 0; c < 4000; c++) begin
      we  = ($urandom_range(0, 9) < 6);
      wa  = ($urandom_range(0, 19) == 0) ?
            AW'(WORDS - 1) : AW'($urandom_range(0, 31));
      wd  = {$urandom, $urandom};
      sd  = ($urandom_range(0, 9) == 0);
      cre = 1'($urandom_range(0, 1));
      cra = AW'($urandom_range(0, 31));
      acc = ($urandom_range(0, 11) == 0);
      rej = ($urandom_range(0, 11) == 0);
      fre = 1'($urandom_range(0, 1));
      fra = AW'($urandom_range(0, 31));
      fdone = ($urandom_range(0, 7) == 0);
      tick();
    end
    idle();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
